fetch_pc_stage: RTL

- Instruction-fetch stage of the 5-stage pipelined 64-bit ARM CPU.
- Holds the program counter and selects next-PC: sequential PC+4, or a redirect target resolved downstream.
- Registers the fetched instruction and its PC into the IF/ID pipeline register that feeds decode.
- Next-PC selection is built from the team's gate-level 2:1 mux cells, one per bit of the 64-bit path.

---
 rtl/fetch_pc_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage of the 64-bit pipelined ARM core: PC register,
// next-PC selection built from per-bit 2:1 mux cells, and the IF/ID register.

module mux2_cell (
    input  logic sel,
    input  logic i0,
    input  logic i1,
    output logic y
);
    assign y = (i0 & ~sel) | (i1 & sel);
endmodule

module fetch_pc_stage #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'hD503201F
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [31:0]       imem_instr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic [31:0]       fetch_count
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [31:0]       fetch_count_q, fetch_count_d;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // The stall mux sits ahead of the redirect mux so a redirect always wins.
    for (genvar i = 0; i < ADDR_W; i++) begin : g_next_pc
        mux2_cell u_stall_mux (
            .sel (stall),
            .i0  (pc_plus4[i]),
            .i1  (pc_q[i]),
            .y   (seq_pc[i])
        );
        mux2_cell u_redirect_mux (
            .sel (redirect),
            .i0  (seq_pc[i]),
            .i1  (redirect_pc[i]),
            .y   (pc_d[i])
        );
    end

    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;
        if (redirect) begin
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_instr;
            if_id_valid_d = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign fetch_count = fetch_count_q;

endmodule
